// File: rtl/sseg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyph table,
// blank pattern and the per-cycle slot phase used to decide anode drive.
package sseg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Cathode patterns {g,f,e,d,c,b,a}, active-low, indexed by hex value
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic [1:0] {
      SLOT_GUARD,
      SLOT_LIT,
      SLOT_DARK
   } slot_phase_e;

   function automatic logic [6:0] hexGlyph(input logic [3:0] hex);
      return GLYPH_TABLE[hex];
   endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Digit/control inputs and display pin outputs of the scan driver, grouped so
// the upstream counter block and the driver share one bundle.
interface sseg_scan_driver_if #(
   parameter int NUM_DIGITS = 8
);

   logic [4*NUM_DIGITS-1:0] ssd_digits;
   logic [NUM_DIGITS-1:0]   ssd_dp_in;
   logic [NUM_DIGITS-1:0]   ssd_digit_en;
   logic                    ssd_lzb;
   logic [NUM_DIGITS-1:0]   ssd_an;
   logic [6:0]              ssd_seg;
   logic                    ssd_dp;
   logic                    ssd_frame;

   modport master (
      output ssd_digits, ssd_dp_in, ssd_digit_en, ssd_lzb,
      input  ssd_an, ssd_seg, ssd_dp, ssd_frame
   );

   modport slave (
      input  ssd_digits, ssd_dp_in, ssd_digit_en, ssd_lzb,
      output ssd_an, ssd_seg, ssd_dp, ssd_frame
   );

endinterface

// File: rtl/sseg_scan_driver_hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_sseg
   import sseg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = hexGlyph(hex_i);
   end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed common-anode display driver: scans a per-frame snapshot of
// the digit inputs, one digit per refresh slot, with a dark guard at slot start.
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 16
) (
   input logic               ssd_clk,
   input logic               ssd_rst_n,
   sseg_scan_driver_if.slave bus
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(REFRESH_DIV);

   logic [CW-1:0]           prescale_q, prescale_d;
   logic [IW-1:0]           slotIdx_q, slotIdx_d;
   logic [4*NUM_DIGITS-1:0] shDigits_q;
   logic [NUM_DIGITS-1:0]   shDp_q;
   logic [NUM_DIGITS-1:0]   shEn_q;
   logic                    shLzb_q;
   logic                    frame_q, frame_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q;
   logic                    dp_q, dp_d;

   logic                    tick;
   logic                    frameStart;
   logic                    zeroLead;
   logic                    dark;
   logic [3:0]              curHex;
   logic [6:0]              curGlyph;
   slot_phase_e             phase;

   // A frame begins on the tick that wraps the slot index back to digit 0
   always_comb begin
      tick       = (prescale_q == CW'(REFRESH_DIV - 1));
      prescale_d = tick ? '0 : prescale_q + CW'(1);
      frameStart = tick && (slotIdx_q == IW'(NUM_DIGITS - 1));
      frame_d    = frameStart;
      slotIdx_d  = slotIdx_q;
      if (tick) begin
         slotIdx_d = frameStart ? '0 : slotIdx_q + IW'(1);
      end
   end

   // Leading-zero blanking looks at the current digit and everything to its left
   always_comb begin
      zeroLead = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= int'(slotIdx_q) && shDigits_q[4*i +: 4] != 4'h0) begin
            zeroLead = 1'b0;
         end
      end
      dark = !shEn_q[slotIdx_q] ||
             (shLzb_q && (slotIdx_q != '0) && zeroLead);
      curHex = shDigits_q[4*int'(slotIdx_q) +: 4];
   end

   hex_to_sseg u_glyph (
      .hex_i (curHex),
      .seg_o (curGlyph)
   );

   // Anode only goes low once the guard interval of the slot has elapsed
   always_comb begin
      if (prescale_q < CW'(GUARD)) begin
         phase = SLOT_GUARD;
      end else if (dark) begin
         phase = SLOT_DARK;
      end else begin
         phase = SLOT_LIT;
      end
      an_d = '1;
      if (phase == SLOT_LIT) begin
         an_d[slotIdx_q] = 1'b0;
      end
      dp_d = ~shDp_q[slotIdx_q];
   end

   // Counters, frame snapshot and registered pin drivers
   always_ff @(posedge ssd_clk or negedge ssd_rst_n) begin
      if (!ssd_rst_n) begin
         prescale_q <= '0;
         slotIdx_q  <= IW'(NUM_DIGITS - 1);
         shDigits_q <= '0;
         shDp_q     <= '0;
         shEn_q     <= '0;
         shLzb_q    <= 1'b0;
         frame_q    <= 1'b0;
         an_q       <= '1;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
      end else begin
         prescale_q <= prescale_d;
         slotIdx_q  <= slotIdx_d;
         frame_q    <= frame_d;
         an_q       <= an_d;
         seg_q      <= curGlyph;
         dp_q       <= dp_d;
         if (frameStart) begin
            shDigits_q <= bus.ssd_digits;
            shDp_q     <= bus.ssd_dp_in;
            shEn_q     <= bus.ssd_digit_en;
            shLzb_q    <= bus.ssd_lzb;
         end
      end
   end

   assign bus.ssd_an    = an_q;
   assign bus.ssd_seg   = seg_q;
   assign bus.ssd_dp    = dp_q;
   assign bus.ssd_frame = frame_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: glyph/blanking vector table, hand-written reset and
// snapshot sequences, and randomized inputs against a cycle-count reference model.
module tb_sseg_scan_driver;

   localparam int N     = 4;
   localparam int DIV   = 8;
   localparam int GUARD = 2;

   logic ssd_clk   = 1'b0;
   logic ssd_rst_n = 1'b1;

   sseg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

   sseg_scan_driver #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (DIV),
      .GUARD       (GUARD)
   ) dut (
      .ssd_clk   (ssd_clk),
      .ssd_rst_n (ssd_rst_n),
      .bus       (bus)
   );

   always #5 ssd_clk = ~ssd_clk;

   typedef struct {
      logic [15:0] digits;
      logic [3:0]  dpIn;
      logic [3:0]  en;
      logic        lzb;
      logic [3:0]  lit;
      logic [27:0] segs;
      logic [3:0]  dpOut;
   } vec_t;

   logic [6:0] glyphTab [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   logic [3:0] walk [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

   int checks = 0;
   int errors = 0;

   int          edgeCount;
   logic [15:0] snapDigits;
   logic [3:0]  snapDp;
   logic [3:0]  snapEn;
   logic        snapLzb;
   logic [3:0]  expAn;
   logic [6:0]  expSeg;
   logic        expDp;
   logic        expFrame;

   vec_t       vecs [8];
   int         firstFrame;
   logic [3:0] anT;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp,
                                input logic [3:0] en, input logic lzb);
      bus.ssd_digits   = d;
      bus.ssd_dp_in    = dp;
      bus.ssd_digit_en = en;
      bus.ssd_lzb      = lzb;
   endtask

   task automatic modelReset();
      edgeCount  = 0;
      snapDigits = '0;
      snapDp     = '0;
      snapEn     = '0;
      snapLzb    = 1'b0;
      expAn      = 4'hF;
      expSeg     = 7'h7F;
      expDp      = 1'b1;
      expFrame   = 1'b0;
   endtask

   // Pins after an edge reflect the scan position reached after the previous edge
   task automatic modelEdge();
      int   m;
      int   idx;
      int   pre;
      logic dk;
      m   = edgeCount;
      idx = (N - 1 + m / DIV) % N;
      pre = m % DIV;
      dk  = !snapEn[idx] ||
            (snapLzb && idx != 0 && (snapDigits >> (4 * idx)) == 16'h0);
      expAn = 4'hF;
      if (pre >= GUARD && !dk) expAn[idx] = 1'b0;
      expSeg = glyphTab[snapDigits[4*idx +: 4]];
      expDp  = ~snapDp[idx];
      edgeCount++;
      expFrame = (edgeCount % DIV == 0) && ((edgeCount / DIV) % N == 1);
      if (expFrame) begin
         snapDigits = bus.ssd_digits;
         snapDp     = bus.ssd_dp_in;
         snapEn     = bus.ssd_digit_en;
         snapLzb    = bus.ssd_lzb;
      end
   endtask

   task automatic checkOutput();
      checkVal("an", bus.ssd_an, expAn);
      checkVal("frame", bus.ssd_frame, expFrame);
      if (expAn != 4'hF) begin
         checkVal("seg", bus.ssd_seg, expSeg);
         checkVal("dp", bus.ssd_dp, expDp);
      end
   endtask

   task automatic stepCycle();
      @(posedge ssd_clk);
      modelEdge();
      @(negedge ssd_clk);
      checkOutput();
   endtask

   task automatic waitFrame();
      bit seen;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         stepCycle();
         if (bus.ssd_frame === 1'b1) seen = 1;
      end
      if (!seen) begin
         errors++;
         $display("[TB] FAIL frame_timeout: got no frame expected frame within 100 cycles");
      end
   endtask

   task automatic checkResetPins(input string tag);
      checkVal({tag, "_an"}, bus.ssd_an, 4'hF);
      checkVal({tag, "_seg"}, bus.ssd_seg, 7'h7F);
      checkVal({tag, "_dp"}, bus.ssd_dp, 1'b1);
      checkVal({tag, "_frame"}, bus.ssd_frame, 1'b0);
   endtask

   function automatic logic [15:0] randDigits();
      logic [15:0] d;
      for (int i = 0; i < N; i++)
         d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      return d;
   endfunction

   initial begin
      vecs[0] = '{16'h0123, 4'h0, 4'hF, 1'b0, 4'hF, {7'h40, 7'h79, 7'h24, 7'h30}, 4'hF};
      vecs[1] = '{16'h4567, 4'h0, 4'hF, 1'b0, 4'hF, {7'h19, 7'h12, 7'h02, 7'h78}, 4'hF};
      vecs[2] = '{16'h89AB, 4'h0, 4'hF, 1'b0, 4'hF, {7'h00, 7'h10, 7'h08, 7'h03}, 4'hF};
      vecs[3] = '{16'hCDEF, 4'h0, 4'hF, 1'b0, 4'hF, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'hF};
      vecs[4] = '{16'h0050, 4'h0, 4'hF, 1'b1, 4'h3, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF};
      vecs[5] = '{16'h0000, 4'h0, 4'hF, 1'b1, 4'h1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF};
      vecs[6] = '{16'h1234, 4'h4, 4'h5, 1'b0, 4'h5, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hB};
      vecs[7] = '{16'h0F00, 4'h0, 4'hF, 1'b1, 4'h7, {7'h40, 7'h0E, 7'h40, 7'h40}, 4'hF};

      // Reset held with inputs toggling
      applyStimulus(16'h0, 4'h0, 4'h0, 1'b0);
      #1 ssd_rst_n = 1'b0;
      modelReset();
      for (int i = 0; i < 5; i++) begin
         @(negedge ssd_clk);
         applyStimulus(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
         checkResetPins("reset");
      end

      // Release: first frame after DIV cycles, then anodes walk E,D,B,7,E
      applyStimulus(16'h1234, 4'h0, 4'hF, 1'b0);
      @(negedge ssd_clk);
      ssd_rst_n  = 1'b1;
      firstFrame = -1;
      for (int n = 1; n <= 44; n++) begin
         stepCycle();
         if (bus.ssd_frame === 1'b1 && firstFrame < 0) firstFrame = n;
         if (n >= 12 && (n - 12) % 8 == 0) checkVal("an_walk", bus.ssd_an, walk[(n - 12) / 8]);
      end
      checkVal("first_frame_cycle", firstFrame, 8);

      // Vector table: one frame per record, sampled mid-slot after the guard
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].digits, vecs[v].dpIn, vecs[v].en, vecs[v].lzb);
         waitFrame();
         for (int n = 1; n <= 28; n++) begin
            stepCycle();
            if (n % 8 == 4) begin
               int j;
               j   = (n - 4) / 8;
               anT = vecs[v].lit[j] ? ~(4'b0001 << j) : 4'hF;
               checkVal($sformatf("vec%0d_an%0d", v, j), bus.ssd_an, anT);
               if (vecs[v].lit[j]) begin
                  checkVal($sformatf("vec%0d_seg%0d", v, j), bus.ssd_seg, vecs[v].segs[7*j +: 7]);
                  checkVal($sformatf("vec%0d_dp%0d", v, j), bus.ssd_dp, vecs[v].dpOut[j]);
               end
            end
         end
      end

      // Mid-frame input change must not tear the current frame
      applyStimulus(16'h1111, 4'h0, 4'hF, 1'b0);
      waitFrame();
      for (int n = 1; n <= 28; n++) begin
         stepCycle();
         if (n == 10) applyStimulus(16'h2222, 4'h0, 4'hF, 1'b0);
         if (n > 10 && n % 8 == 4) checkVal("snap_old_seg", bus.ssd_seg, 7'h79);
      end
      waitFrame();
      for (int n = 1; n <= 4; n++) stepCycle();
      checkVal("snap_new_seg", bus.ssd_seg, 7'h24);
      checkVal("snap_new_an", bus.ssd_an, 4'hE);

      // Randomized inputs, changed at arbitrary points in the scan
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 11) == 0)
            applyStimulus(randDigits(), 4'($urandom), 4'($urandom), 1'($urandom));
         stepCycle();
      end

      // Asynchronous reset between clock edges, then a fresh scan
      applyStimulus(16'h1234, 4'h0, 4'hF, 1'b0);
      waitFrame();
      for (int n = 1; n <= 12; n++) stepCycle();
      @(posedge ssd_clk);
      #2 ssd_rst_n = 1'b0;
      #1 checkResetPins("async_reset");
      modelReset();
      applyStimulus(16'hABCD, 4'h1, 4'hF, 1'b0);
      @(negedge ssd_clk);
      ssd_rst_n  = 1'b1;
      firstFrame = -1;
      for (int n = 1; n <= 20; n++) begin
         stepCycle();
         if (bus.ssd_frame === 1'b1 && firstFrame < 0) firstFrame = n;
         if (n == 12) begin
            checkVal("restart_an", bus.ssd_an, 4'hE);
            checkVal("restart_seg", bus.ssd_seg, 7'h21);
            checkVal("restart_dp", bus.ssd_dp, 1'b0);
         end
      end
      checkVal("restart_frame_cycle", firstFrame, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
